// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
// State encoding, legal LATENCY range and the latency counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // Bring a requested latency into the legal range so the counter never wraps.
    function automatic int clamp_latency(input int lat);
        if (lat < LATENCY_MIN) return LATENCY_MIN;
        if (lat > LATENCY_MAX) return LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word array.
// Byte-lane write enables derived from the 32-bit bit mask (each byte group of
// the mask is all-0 or all-1), read-first registered read port. The read
// register can be forced to zero for accesses the responder rejects, and is
// cleared by reset; the storage itself is never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_wen,
    input  logic          i_zero,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [31:0]   i_mask,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic [3:0]  w_be;

    // Collapse each 8-bit mask group into one byte enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign w_be[gi] = |i_mask[8*gi +: 8];
        end
    endgenerate

    // Byte-enable write; only lanes whose mask group is set change.
    always_ff @(posedge i_clk) begin
        if (i_en && i_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-first: a write access returns the word as it was before the write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= 32'h0;
        end else if (i_en) begin
            r_rdata <= i_zero ? 32'h0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: target end of the memory stage's dmem request interface.
// Accepts one word access per transaction, touches the word array at the
// accept edge and presents the response LATENCY cycles later through a
// valid/ready handshake. Optional feature macro: DMEM_RANGE_CHECK_EN
// (out-of-range accesses are suppressed and flagged instead of wrapping).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic        i_req_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [31:0] i_dmem_mask,
    output logic        o_rsp_vld,
    input  logic        i_rsp_rdy,
    output logic [31:0] o_dmem_rdata,
    output logic        o_rsp_err
);

    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int LAT_EFF = clamp_latency(LATENCY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_vld;

    logic [31:0] w_offset;
    logic [29:0] w_word;
    logic        w_accept;
    logic        w_arr_wen;
    logic        w_arr_zero;
    logic        w_unused_lo;

    // Word index relative to BASE_ADDR; unsigned, so addresses below the base
    // turn into huge indices and land out of range.
    assign w_offset    = i_dmem_addr - BASE_ADDR;
    assign w_word      = w_offset[31:2];
    assign w_unused_lo = ^w_offset[1:0];

    // A request is taken only in IDLE; reset wins over a coincident request.
    assign w_accept  = (r_state == ST_IDLE) && i_req_vld && !i_rst;
    assign o_req_rdy = (r_state == ST_IDLE);

`ifdef DMEM_RANGE_CHECK_EN
    logic w_in_range;
    logic r_err;

    assign w_in_range = ({2'b00, w_word} < 32'(DEPTH_WORDS));
    assign w_arr_wen  = i_req_wen && w_in_range;
    assign w_arr_zero = !w_in_range;
    assign o_rsp_err  = r_err;

    // Error flag is captured with the access and held for the whole response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= !w_in_range;
        end
    end
`else
    logic w_unused_hi;

    // Without range checking the index simply wraps onto the array.
    assign w_unused_hi = ^w_word[29:AW];
    assign w_arr_wen   = i_req_wen;
    assign w_arr_zero  = 1'b0;
    assign o_rsp_err   = 1'b0;
`endif

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_accept),
        .i_wen   (w_arr_wen),
        .i_zero  (w_arr_zero),
        .i_addr  (w_word[AW-1:0]),
        .i_wdata (i_dmem_wdata),
        .i_mask  (i_dmem_mask),
        .o_rdata (o_dmem_rdata)
    );

    // Transaction FSM: count the latency down, then hold the response until taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rsp_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_vld) begin
                        if (LAT_EFF == 1) begin
                            r_state   <= ST_RESP;
                            r_rsp_vld <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(LAT_EFF - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= ST_RESP;
                        r_rsp_vld <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_rdy) begin
                        r_state   <= ST_IDLE;
                        r_rsp_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign o_rsp_vld = r_rsp_vld;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: self-checking bench for dmem_resp.
// Instance A (LATENCY=2) runs a table of transactions through a scoreboard;
// instance B (LATENCY=1, response ready tied high) checks back-to-back reads.
// Expectations follow DMEM_RANGE_CHECK_EN when it is defined for the build.
module tb_dmem_resp;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    localparam int LAT_A = 2;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        chk;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_req_vld = 1'b0, a_req_wen = 1'b0, a_rsp_rdy = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, a_mask = '0;
    logic        a_req_rdy, a_rsp_vld, a_err;
    logic [31:0] a_rdata;

    logic        b_rst = 1'b1, b_req_vld = 1'b0, b_req_wen = 1'b0, b_rsp_rdy = 1'b1;
    logic [31:0] b_addr = '0, b_wdata = '0, b_mask = '0;
    logic        b_req_rdy, b_rsp_vld, b_err;
    logic [31:0] b_rdata;

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_req_vld(a_req_vld), .o_req_rdy(a_req_rdy),
        .i_req_wen(a_req_wen), .i_dmem_addr(a_addr), .i_dmem_wdata(a_wdata),
        .i_dmem_mask(a_mask), .o_rsp_vld(a_rsp_vld), .i_rsp_rdy(a_rsp_rdy),
        .o_dmem_rdata(a_rdata), .o_rsp_err(a_err)
    );

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_req_vld(b_req_vld), .o_req_rdy(b_req_rdy),
        .i_req_wen(b_req_wen), .i_dmem_addr(b_addr), .i_dmem_wdata(b_wdata),
        .i_dmem_mask(b_mask), .o_rsp_vld(b_rsp_vld), .i_rsp_rdy(b_rsp_rdy),
        .o_dmem_rdata(b_rdata), .o_rsp_err(b_err)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mask, input int hold, input logic [31:0] er,
                                input logic ee, input logic chk);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask; v.hold = hold;
        v.exp_rdata = er; v.exp_err = ee; v.chk = chk;
        return v;
    endfunction

    // One full transaction on instance A: request, latency, optional backpressure, handshake.
    task automatic run_txn(input vec_t v, input int id);
        exp_t        e;
        int          k;
        logic [31:0] held;
        k = 0;
        while (!a_req_rdy && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("req_rdy_idle", {31'b0, a_req_rdy}, 32'd1);
        a_req_vld = 1'b1; a_req_wen = v.wen; a_addr = v.addr; a_wdata = v.wdata; a_mask = v.mask;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.chk = v.chk;
        sb.push_back(e);
        @(posedge clk); #1;
        a_req_vld = 1'b0;
        k = 1;
        while (!a_rsp_vld && k < 20) begin
            check("req_rdy_busy", {31'b0, a_req_rdy}, 32'd0);
            @(posedge clk); #1; k++;
        end
        check("latency", k, LAT_A);
        held = a_rdata;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            check("bp_vld", {31'b0, a_rsp_vld}, 32'd1);
            check("bp_data", a_rdata, held);
            check("bp_req_rdy", {31'b0, a_req_rdy}, 32'd0);
        end
        e = sb.pop_front();
        if (e.chk) check("rdata", a_rdata, e.rdata);
        check("err", {31'b0, a_err}, {31'b0, e.err});
        $display("txn %0d: wen=%0d addr=%h wdata=%h mask=%h hold=%0d -> rdata=%h err=%0d",
                 id, v.wen, v.addr, v.wdata, v.mask, v.hold, a_rdata, a_err);
        a_rsp_rdy = 1'b1;
        @(posedge clk); #1;
        a_rsp_rdy = 1'b0;
        check("vld_drop", {31'b0, a_rsp_vld}, 32'd0);
        check("req_rdy_back", {31'b0, a_req_rdy}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0]  = mk(1'b1, 32'h10,   32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 32'h10,   32'h0,        32'h0,        0, 32'hDEADBEEF, 1'b0, 1'b1);
        vecs[2]  = mk(1'b1, 32'h20,   32'h11223344, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 32'h20,   32'h0000AA00, 32'h0000FF00, 0, 32'h11223344, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 32'h20,   32'h0,        32'h0,        0, 32'h1122AA44, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 32'h22,   32'h0,        32'h0,        5, 32'h1122AA44, 1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 32'h20,   32'h99000000, 32'hFF000000, 1, 32'h1122AA44, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 32'h20,   32'h0,        32'h0,        0, 32'h9922AA44, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 32'h0,    32'h01234567, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 32'h1000, 32'hCAFEF00D, 32'hFFFFFFFF, 0,
                      RC ? 32'h0 : 32'h01234567, RC, 1'b1);
        vecs[10] = mk(1'b0, 32'h0,    32'h0,        32'h0,        0,
                      RC ? 32'h01234567 : 32'hCAFEF00D, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 32'h1000, 32'h0,        32'h0,        0,
                      RC ? 32'h0 : 32'hCAFEF00D, RC, 1'b1);
        vecs[12] = mk(1'b1, 32'h10,   32'hFFFFFFFF, 32'h0,        0, 32'hDEADBEEF, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 32'h13,   32'h0,        32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 32'hFFFFFFF0, 32'h0,    32'h0,        0, 32'h0,        RC,   RC);
        vecs[15] = mk(1'b1, 32'h3000, 32'h0BADF00D, 32'hFFFFFFFF, 0,
                      RC ? 32'h0 : 32'hCAFEF00D, RC, 1'b1);
        vecs[16] = mk(1'b0, 32'h0,    32'h0,        32'h0,        0,
                      RC ? 32'h01234567 : 32'h0BADF00D, 1'b0, 1'b1);

        // Reset both instances and check the reset state of A.
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;
        check("rst_req_rdy", {31'b0, a_req_rdy}, 32'd1);
        check("rst_rsp_vld", {31'b0, a_rsp_vld}, 32'd0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_err", {31'b0, a_err}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset while in WAIT after a write accept: response discarded, write kept.
        a_req_vld = 1'b1; a_req_wen = 1'b1; a_addr = 32'h40; a_wdata = 32'h13579BDF; a_mask = 32'hFFFFFFFF;
        @(posedge clk); #1;
        a_req_vld = 1'b0;
        check("wait_req_rdy", {31'b0, a_req_rdy}, 32'd0);
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        check("midrst_rsp_vld", {31'b0, a_rsp_vld}, 32'd0);
        check("midrst_req_rdy", {31'b0, a_req_rdy}, 32'd1);
        check("midrst_rdata", a_rdata, 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | a_rsp_vld;
        end
        check("midrst_no_rsp", {31'b0, seen}, 32'd0);
        $display("txn reset-in-wait: write addr=00000040 discarded response, rsp_vld seen=%0d", seen);
        run_txn(mk(1'b0, 32'h40, 32'h0, 32'h0, 0, 32'h13579BDF, 1'b0, 1'b1), 100);

        // Instance B, LATENCY=1 with response ready tied high.
        b_req_vld = 1'b1; b_req_wen = 1'b1; b_addr = 32'h8; b_wdata = 32'hA5A50F0F; b_mask = 32'hFFFFFFFF;
        @(posedge clk); #1;
        b_req_vld = 1'b0;
        check("b_wr_vld", {31'b0, b_rsp_vld}, 32'd1);
        check("b_wr_req_rdy", {31'b0, b_req_rdy}, 32'd0);
        @(posedge clk); #1;
        check("b_wr_vld_drop", {31'b0, b_rsp_vld}, 32'd0);
        check("b_wr_req_rdy_back", {31'b0, b_req_rdy}, 32'd1);
        $display("txn b-write: addr=00000008 wdata=a5a50f0f");

        b_req_vld = 1'b1; b_req_wen = 1'b0; b_addr = 32'h8;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("b_b2b_vld", {31'b0, b_rsp_vld}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("b_b2b_req_rdy", {31'b0, b_req_rdy}, (i % 2 == 1) ? 32'd0 : 32'd1);
            if (i % 2 == 1) begin
                check("b_b2b_rdata", b_rdata, 32'hA5A50F0F);
                check("b_b2b_err", {31'b0, b_err}, 32'd0);
                $display("txn b-read %0d: addr=00000008 -> rdata=%h err=%0d", i / 2, b_rdata, b_err);
            end
        end
        b_req_vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder: the target end of the memory stage's dmem request interface. Accepts one word-aligned read or write per transaction (address, write data, 32-bit bit-mask), updates or reads its word array, and returns read data after a fixed, parameterised latency through a valid/ready response handshake. Sits between the pipeline's memory stage and the data storage, replacing the ideal zero-latency memory model.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  responder can accept a request.
- i_req_wen  in  1  1 = write, 0 = read.
- i_dmem_addr  in  32  byte address; bits [1:0] ignored.
- i_dmem_wdata  in  32  write data, already lane-aligned by the initiator.
- i_dmem_mask  in  32  per-bit write enable; byte groups are all-0 or all-1.
- o_rsp_vld  out  1  response valid.
- i_rsp_rdy  in  1  initiator accepts response.
- o_dmem_rdata  out  32  full read word (unaligned; initiator extracts lanes).
- o_rsp_err  out  1  address out of range (see Configuration).

## Operation
- States: IDLE, WAIT, RESP. o_req_rdy = (state == IDLE), combinational from state.
- IDLE: on i_req_vld && o_req_rdy, accept. Write: mem[idx] <= (mem[idx] & ~mask) | (wdata & mask) at the accept edge. Read: mem[idx] captured into rdata register at the accept edge. Write responses return o_dmem_rdata = pre-write word.
- Go to WAIT with counter = LATENCY-1; if LATENCY == 1 go straight to RESP.
- WAIT: decrement counter each cycle; at counter == 1 go to RESP.
- RESP: o_rsp_vld = 1, o_dmem_rdata and o_rsp_err held stable until i_rsp_rdy; on i_rsp_rdy go to IDLE.
- idx = (i_dmem_addr - BASE_ADDR) >> 2; in range iff idx < DEPTH_WORDS (subtraction unsigned, underflow counts as out of range).
- Request inputs are ignored outside IDLE; initiator must hold them until accepted.
- Mask of all zeros on a write is a legal no-op write.

## Timing
- Accept at edge N: o_rsp_vld high after edge N+LATENCY; drops after the edge where i_rsp_rdy is sampled high.
- Same-cycle response handshake and new request impossible: o_req_rdy rises the cycle after response handshake. Max throughput one transaction per LATENCY+1 cycles.
- Read-after-write to same word in consecutive transactions returns new data.
- Reset values: state IDLE, o_req_rdy 1, o_rsp_vld 0, o_dmem_rdata 0, o_rsp_err 0, counter 0. Memory contents not reset.
- Reset mid-transaction: pending response discarded, IDLE next cycle; a write already committed at accept stays committed.

## Configuration
- DMEM_RANGE_CHECK_EN defined: out-of-range write suppressed, out-of-range read returns 0, o_rsp_err = 1 for that response; latency unchanged.
- Undefined: idx uses its low log2(DEPTH_WORDS) bits (wraps), all accesses proceed, o_rsp_err tied 0.

## Structure
- Shared package dmem_pkg: state encoding (IDLE/WAIT/RESP), LATENCY min/max constants, counter width (4 bits).
- One sub-module: dmem_array — single-port synchronous word array with bit-mask write and registered read; dmem_resp holds FSM, counter, range check, response register.

## Test plan
- LATENCY=2: write 0xDEADBEEF, mask 0xFFFFFFFF, addr 0x10; then read 0x10 -> rsp_vld 2 cycles after each accept, read data 0xDEADBEEF, err 0.
- Byte write: word at 0x20 = 0x11223344, write 0x0000AA00 mask 0x0000FF00 -> subsequent read returns 0x1122AA44.
- Backpressure: hold i_rsp_rdy low 5 cycles -> o_rsp_vld and data stable, o_req_rdy 0 throughout; rdy rises cycle after handshake.
- Range: DEPTH_WORDS=1024, write addr 0x1000 -> with DMEM_RANGE_CHECK_EN err 1 and word 0 unchanged; without it, word 0 overwritten, err 0.
- Reset in WAIT after a write accept -> o_rsp_vld never asserts, o_req_rdy 1 next cycle, subsequent read returns written data.
- LATENCY=1 back-to-back reads with i_rsp_rdy tied high -> one accept every 2 cycles, rsp_vld 1 cycle after each accept.
